// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU bus bridge: FSM encoding, address area
// prefixes, the word returned on faulted accesses and counter widths.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RESP  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  // Top two address bits select the area
  localparam logic [1:0] AREA_ROM      = 2'h0;
  localparam logic [1:0] AREA_RAM      = 2'h1;
  localparam logic [1:0] AREA_RESERVED = 2'h2;
  localparam logic [1:0] AREA_MMIO     = 2'h3;

  // Returned to the CPU on any fault so a faulted fetch traps
  localparam logic [31:0] ILLEGAL_INSTRUCTION = 32'h0;

  localparam int FAULT_COUNT_W = 8;
  localparam logic [FAULT_COUNT_W-1:0] FAULT_COUNT_MAX = '1;

  // Wait timer width covers the largest legal timeout (255)
  localparam int TIMER_W = 8;

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-cycle counter for the bus bridge. Clear has priority over enable;
// terminal is high while the count sits at TIMEOUT_CYCLES-1.
module bus_wait_timer
  import cpu_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [TIMER_W-1:0] count;

  // Count request cycles; restart whenever the bridge is idle
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == TIMER_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cpu_bus_bridge.sv
// Registered bridge between the picorv32 memory port and the address
// decoder. Aborts accesses that wait too long and blocks ROM writes; both
// complete the CPU access with ILLEGAL_INSTRUCTION and pulse fault.
// Optional fault log (fault_addr/fault_count/clear_fault): define
// BUS_FAULT_LOG_EN to enable it, otherwise those outputs are tied to 0.
module cpu_bus_bridge
  import cpu_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_valid,
  input  logic        cpu_instr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  output logic        bus_valid,
  output logic        bus_instr,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  input  logic        clear_fault,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [7:0]  fault_count
);

  state_t state;
  logic   timer_terminal;
  logic   rom_write;

  assign rom_write = (cpu_addr[31:30] == AREA_ROM) && (cpu_wstrb != 4'h0);

  bus_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == ST_IDLE),
    .enable  (state == ST_REQ),
    .terminal(timer_terminal)
  );

  // Access FSM with all CPU- and bus-facing outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      bus_valid <= 1'b0;
      bus_instr <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
      fault     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cpu_ready <= 1'b0;
          fault     <= 1'b0;
          if (cpu_valid) begin
            bus_instr <= cpu_instr;
            bus_addr  <= cpu_addr;
            bus_wdata <= cpu_wdata;
            bus_wstrb <= cpu_wstrb;
            if (rom_write) begin
              // Never forwarded: answer straight away as a fault
              state     <= ST_FAULT;
              cpu_ready <= 1'b1;
              cpu_rdata <= ILLEGAL_INSTRUCTION;
              fault     <= 1'b1;
            end else begin
              state     <= ST_REQ;
              bus_valid <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          // A ready on the terminal cycle still completes normally
          if (bus_ready) begin
            state     <= ST_RESP;
            bus_valid <= 1'b0;
            cpu_ready <= 1'b1;
            cpu_rdata <= bus_rdata;
          end else if (timer_terminal) begin
            state     <= ST_FAULT;
            bus_valid <= 1'b0;
            cpu_ready <= 1'b1;
            cpu_rdata <= ILLEGAL_INSTRUCTION;
            fault     <= 1'b1;
          end
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          cpu_ready <= 1'b0;
        end
        ST_FAULT: begin
          state     <= ST_IDLE;
          cpu_ready <= 1'b0;
          fault     <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          cpu_ready <= 1'b0;
          bus_valid <= 1'b0;
          fault     <= 1'b0;
        end
      endcase
    end
  end

`ifdef BUS_FAULT_LOG_EN
  // Fault log: the fault being completed takes priority over a clear
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_addr  <= '0;
      fault_count <= '0;
    end else if (state == ST_FAULT) begin
      fault_addr <= bus_addr;
      if (clear_fault) begin
        fault_count <= 8'd1;
      end else if (fault_count != FAULT_COUNT_MAX) begin
        fault_count <= fault_count + 8'd1;
      end
    end else if (clear_fault) begin
      fault_addr  <= '0;
      fault_count <= '0;
    end
  end
`else
  logic unused_clear_fault;
  assign unused_clear_fault = clear_fault;
  assign fault_addr  = '0;
  assign fault_count = '0;
`endif

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Directed bench for cpu_bus_bridge with TIMEOUT_CYCLES=8. Inputs change
// 1 time unit after the rising edge; outputs are checked at the same point.
module tb_cpu_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_valid;
  logic        cpu_instr;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        bus_valid;
  logic        bus_instr;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        clear_fault;
  logic        fault;
  logic [31:0] fault_addr;
  logic [7:0]  fault_count;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  cpu_bus_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_valid  (cpu_valid),
    .cpu_instr  (cpu_instr),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_wstrb  (cpu_wstrb),
    .cpu_ready  (cpu_ready),
    .cpu_rdata  (cpu_rdata),
    .bus_valid  (bus_valid),
    .bus_instr  (bus_instr),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_wstrb  (bus_wstrb),
    .bus_ready  (bus_ready),
    .bus_rdata  (bus_rdata),
    .clear_fault(clear_fault),
    .fault      (fault),
    .fault_addr (fault_addr),
    .fault_count(fault_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic request(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    cpu_valid = 1'b1;
    cpu_instr = 1'b0;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_wstrb = wstrb;
  endtask

  // Expected fault-log values depend on whether the log is built in
  function automatic logic [31:0] log_exp(input logic [31:0] v);
`ifdef BUS_FAULT_LOG_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  initial begin
    int n_valid;
    logic early_ready;

    reset = 1'b1; cpu_valid = 1'b0; cpu_instr = 1'b0; cpu_addr = '0;
    cpu_wdata = '0; cpu_wstrb = '0; bus_ready = 1'b0; bus_rdata = '0;
    clear_fault = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_cpu_ready", 32'(cpu_ready), 32'h0);
    chk("rst_bus_valid", 32'(bus_valid), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_fault_count", 32'(fault_count), 32'h0);
    reset = 1'b0;
    tick();

    // RAM read, ready on the 3rd bus_valid cycle
    request(32'h4000_0010, 32'h0, 4'h0);
    tick();
    cpu_valid = 1'b0;
    chk("ram_bus_valid_c1", 32'(bus_valid), 32'h1);
    chk("ram_bus_addr", bus_addr, 32'h4000_0010);
    tick();
    chk("ram_bus_valid_c2", 32'(bus_valid), 32'h1);
    tick();
    chk("ram_bus_valid_c3", 32'(bus_valid), 32'h1);
    chk("ram_no_early_ready", 32'(cpu_ready), 32'h0);
    bus_ready = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    tick();
    bus_ready = 1'b0; bus_rdata = '0;
    chk("ram_cpu_ready", 32'(cpu_ready), 32'h1);
    chk("ram_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("ram_fault", 32'(fault), 32'h0);
    chk("ram_bus_valid_drop", 32'(bus_valid), 32'h0);
    tick();
    chk("ram_ready_one_cycle", 32'(cpu_ready), 32'h0);

    // ROM write is blocked
    request(32'h0000_0100, 32'h1234_5678, 4'hF);
    tick();
    cpu_valid = 1'b0;
    chk("rom_bus_valid", 32'(bus_valid), 32'h0);
    chk("rom_cpu_ready", 32'(cpu_ready), 32'h1);
    chk("rom_cpu_rdata", cpu_rdata, 32'h0);
    chk("rom_fault", 32'(fault), 32'h1);
    tick();
    chk("rom_fault_pulse_end", 32'(fault), 32'h0);
    chk("rom_ready_end", 32'(cpu_ready), 32'h0);
    chk("rom_fault_addr", fault_addr, log_exp(32'h0000_0100));
    chk("rom_fault_count", 32'(fault_count), log_exp(32'h1));

    // MMIO read with no ready: timeout after 8 bus_valid cycles
    request(32'hC000_0000, 32'h0, 4'h0);
    tick();
    cpu_valid = 1'b0;
    n_valid = 0;
    early_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!bus_valid) break;
      n_valid++;
      if (cpu_ready) early_ready = 1'b1;
      tick();
    end
    chk("to_valid_cycles", 32'(n_valid), 32'd8);
    chk("to_no_early_ready", 32'(early_ready), 32'h0);
    chk("to_cpu_ready", 32'(cpu_ready), 32'h1);
    chk("to_cpu_rdata", cpu_rdata, 32'h0);
    chk("to_fault", 32'(fault), 32'h1);
    tick();
    chk("to_fault_addr", fault_addr, log_exp(32'hC000_0000));
    chk("to_fault_count", 32'(fault_count), log_exp(32'h2));
    // Late ready two cycles after the abort
    bus_ready = 1'b1; bus_rdata = 32'h1111_1111;
    tick();
    bus_ready = 1'b0; bus_rdata = '0;
    chk("late_ready_cpu_ready", 32'(cpu_ready), 32'h0);
    chk("late_ready_bus_valid", 32'(bus_valid), 32'h0);
    tick();
    chk("late_ready_cpu_ready2", 32'(cpu_ready), 32'h0);

    // Ready on the terminal (8th) cycle wins over the timeout
    request(32'h4000_0020, 32'h0, 4'h0);
    tick();
    cpu_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("term_bus_valid_c8", 32'(bus_valid), 32'h1);
    bus_ready = 1'b1; bus_rdata = 32'hA5A5_A5A5;
    tick();
    bus_ready = 1'b0; bus_rdata = '0;
    chk("term_cpu_ready", 32'(cpu_ready), 32'h1);
    chk("term_cpu_rdata", cpu_rdata, 32'hA5A5_A5A5);
    chk("term_fault", 32'(fault), 32'h0);
    tick();
    chk("term_fault_count", 32'(fault_count), log_exp(32'h2));

    // 260 ROM writes: counter saturates at 255
    for (int i = 0; i < 260; i++) begin
      request(32'h0000_0200 + 32'(i * 4), 32'(i), 4'h1);
      tick();
      cpu_valid = 1'b0;
      tick();
    end
    chk("sat_fault_count", 32'(fault_count), log_exp(32'd255));
    chk("sat_fault_addr", fault_addr, log_exp(32'h0000_0200 + 32'd259 * 32'd4));
    // clear_fault coincident with a further fault
    request(32'h0000_0ABC, 32'h0, 4'h3);
    tick();
    cpu_valid = 1'b0;
    chk("clr_fault_pulse", 32'(fault), 32'h1);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    chk("clr_coinc_count", 32'(fault_count), log_exp(32'h1));
    chk("clr_coinc_addr", fault_addr, log_exp(32'h0000_0ABC));
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    chk("clr_count", 32'(fault_count), 32'h0);
    chk("clr_addr", fault_addr, 32'h0);

    // Reset during REQ, then a fresh request
    request(32'h4000_0030, 32'h0, 4'h0);
    tick();
    cpu_valid = 1'b0;
    chk("rmid_bus_valid_before", 32'(bus_valid), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rmid_bus_valid", 32'(bus_valid), 32'h0);
    chk("rmid_cpu_ready", 32'(cpu_ready), 32'h0);
    chk("rmid_bus_addr", bus_addr, 32'h0);
    request(32'h4000_0040, 32'h0, 4'h0);
    tick();
    cpu_valid = 1'b0;
    chk("fresh_bus_valid", 32'(bus_valid), 32'h1);
    bus_ready = 1'b1; bus_rdata = 32'h0BAD_F00D;
    tick();
    bus_ready = 1'b0; bus_rdata = '0;
    chk("fresh_cpu_ready", 32'(cpu_ready), 32'h1);
    chk("fresh_cpu_rdata", cpu_rdata, 32'h0BAD_F00D);
    tick();
    chk("fresh_ready_end", 32'(cpu_ready), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
